// File: rtl/multi_cycle_control_fsm.sv
// multi_cycle_control_fsm: fetch/decode/execute/memory/writeback sequencer for a multi-cycle RV32I subset core
module multi_cycle_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_we,
    output logic               pc_we,
    output logic               pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic               retire,
    output logic               halted,
    output logic [1:0]         trap_cause,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, TRAP
    } state_t;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);
    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] cause_q, cause_d;
    logic       waiting, taken;
    logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, retire_c;
    // state, wait counter and first trap cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
        end
    end
    // next state and per-state datapath controls
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        waiting   = 1'b0;
        taken     = (funct3 == 3'b000 && alu_zero) || (funct3 == 3'b001 && !alu_zero);
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        addr_sel  = 1'b0;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_we_c  = 1'b0;
        wb_sel    = 2'b00;
        retire_c  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                waiting   = 1'b1;
                ir_we_c   = mem_ready;
                pc_we_c   = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_LD, OP_ST: state_d = MEM_ADDR;
                    OP_BR:        state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? BRANCH : TRAP;
                    OP_JAL:       state_d = JAL;
                    OP_JALR:      state_d = JALR;
                    OP_LUI:       state_d = LUI;
                    default:      state_d = TRAP;
                endcase
                cause_d = (state_d == TRAP) ? 2'b01 : cause_q;
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            WB_ALU: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req_c = 1'b1;
                addr_sel  = 1'b1;
                waiting   = 1'b1;
                state_d   = mem_ready ? WB_MEM : MEM_RD;
            end
            WB_MEM: begin
                reg_we_c = 1'b1;
                wb_sel   = 2'b01;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                addr_sel  = 1'b1;
                waiting   = 1'b1;
                retire_c  = mem_ready;
                state_d   = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_we_c   = taken;
                pc_src    = taken;
                retire_c  = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                reg_we_c = 1'b1;
                wb_sel   = 2'b10;
                pc_we_c  = 1'b1;
                pc_src   = 1'b1;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            JALR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we_c   = 1'b1;
                reg_we_c  = 1'b1;
                wb_sel    = 2'b10;
                retire_c  = 1'b1;
                state_d   = FETCH;
            end
            LUI: begin
                reg_we_c = 1'b1;
                wb_sel   = 2'b11;
                retire_c = 1'b1;
                state_d  = FETCH;
            end
            TRAP: state_d = TRAP;
            default: begin
                state_d = TRAP;
                cause_d = 2'b01;
            end
        endcase
        if (waiting && !mem_ready && wait_cnt_q == LIMIT) begin
            state_d = TRAP;
            cause_d = 2'b10;
        end
        wait_cnt_d = (waiting && !mem_ready && state_d == state_q) ? wait_cnt_q + 8'd1 : 8'd0;
    end
    assign mem_req    = mem_req_c & ~rst;
    assign mem_we     = mem_we_c & ~rst;
    assign ir_we      = ir_we_c & ~rst;
    assign pc_we      = pc_we_c & ~rst;
    assign reg_we     = reg_we_c & ~rst;
    assign retire     = retire_c & ~rst;
    assign halted     = (state_q == TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;
endmodule
